stopwatch_ctrl: RTL and testbench

- Sequencing controller for the HLS-generated hh/mm/ss timekeeper. Its `clear`/`start_r` inputs are driven from this block.
- Debounces three push-buttons and runs a run/pause/clear FSM.
- Prescales `ap_clk` into one-cycle `start_r` advance pulses.
- Latches a lap snapshot of the timekeeper's hh/mm/ss outputs.
- Sits between the board I/O pads and the timekeeper inside the chip top.

---
 rtl/stopwatch_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 74 +++++++
 rtl/stopwatch_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
//==============================================================================
// Module      : stopwatch_pkg
// Description : Shared types and constants for the stopwatch sequencing
//               controller. Holds the FSM state encoding and the width of
//               one hh/mm/ss time field.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package stopwatch_pkg;

    // Width of one timekeeper field (hours, minutes or seconds)
    localparam int TF_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        CLEAR = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
//==============================================================================
// Module      : btn_debounce
// Description : Two-flop synchronizer, stable-level debouncer and rising-edge
//               press detector for one raw push-button.
// Ports       : clk_i   - clock
//               rst_ni  - asynchronous active-low reset
//               btn_i   - raw button level, asynchronous to clk_i
//               press_o - one-cycle pulse when the stable level rises
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DEB_CYCLES = 20000,
    parameter int DEB_W      = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q;
    logic             stable_d;
    logic             press_q;
    logic             press_d;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;

    // cnt_q counts consecutive synchronized samples that disagree with the
    // stable level; any agreeing sample restarts the run.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q;
                cnt_d    = '0;
                // Only a 0->1 change of the stable level is a press
                press_d  = sync_q;
            end else begin
                cnt_d = cnt_q + DEB_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= btn_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
//==============================================================================
// Module      : stopwatch_ctrl
// Description : Sequencing controller for the hh/mm/ss timekeeper. Debounces
//               the run/clear/lap buttons, runs the IDLE/RUN/PAUSE/CLEAR FSM,
//               prescales ap_clk into start_r advance pulses and keeps a lap
//               snapshot of the timekeeper outputs.
// Ports       : ap_clk, ap_rst_n        - clock, async active-low reset
//               btn_run/btn_clr/btn_lap - raw active-high buttons
//               hh/mm/ss                - current time from the timekeeper
//               start_r, clear          - one-cycle pulses to the timekeeper
//               lap_hh/lap_mm/lap_ss    - latched lap snapshot
//               lap_valid               - snapshot is valid
//               running                 - FSM is in RUN
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = 1000000,
    parameter int DEB_CYCLES = 20000,
    parameter int CNT_W      = 20,
    parameter int DEB_W      = 15
) (
    input  logic            ap_clk,
    input  logic            ap_rst_n,
    input  logic            btn_run,
    input  logic            btn_clr,
    input  logic            btn_lap,
    input  logic [TF_W-1:0] hh,
    input  logic [TF_W-1:0] mm,
    input  logic [TF_W-1:0] ss,
    output logic            start_r,
    output logic            clear,
    output logic [TF_W-1:0] lap_hh,
    output logic [TF_W-1:0] lap_mm,
    output logic [TF_W-1:0] lap_ss,
    output logic            lap_valid,
    output logic            running
);

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

    logic run_p;
    logic clr_p;
    logic lap_p;

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  presc_q;
    logic [CNT_W-1:0]  presc_d;
    logic              start_q;
    logic              start_d;
    logic              clear_q;
    logic              running_q;
    logic              lap_valid_q;
    logic              lap_valid_d;
    logic [TF_W-1:0]   lap_hh_q;
    logic [TF_W-1:0]   lap_hh_d;
    logic [TF_W-1:0]   lap_mm_q;
    logic [TF_W-1:0]   lap_mm_d;
    logic [TF_W-1:0]   lap_ss_q;
    logic [TF_W-1:0]   lap_ss_d;
    logic              wrap;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_deb_run (
        .clk_i   (ap_clk),
        .rst_ni  (ap_rst_n),
        .btn_i   (btn_run),
        .press_o (run_p)
    );

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_deb_clr (
        .clk_i   (ap_clk),
        .rst_ni  (ap_rst_n),
        .btn_i   (btn_clr),
        .press_o (clr_p)
    );

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_deb_lap (
        .clk_i   (ap_clk),
        .rst_ni  (ap_rst_n),
        .btn_i   (btn_lap),
        .press_o (lap_p)
    );

    assign wrap = (state_q == RUN) && (presc_q == PRESC_LAST);

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        start_d     = 1'b0;
        lap_valid_d = lap_valid_q;
        lap_hh_d    = lap_hh_q;
        lap_mm_d    = lap_mm_q;
        lap_ss_d    = lap_ss_q;

        // The prescaler advances on every RUN cycle, including the one in
        // which a pause is taken, so a wrap there still yields its pulse.
        // A wrap on the cycle that enters CLEAR is suppressed so start_r
        // never coincides with clear.
        if (state_q == RUN) begin
            presc_d = wrap ? '0 : presc_q + CNT_W'(1);
            start_d = wrap && !clr_p;
        end

        if (state_q == CLEAR) begin
            // Presses arriving during CLEAR are intentionally dropped
            state_d = IDLE;
            presc_d = '0;
        end else if (clr_p) begin
            state_d     = CLEAR;
            lap_valid_d = 1'b0;
            lap_hh_d    = '0;
            lap_mm_d    = '0;
            lap_ss_d    = '0;
        end else if (run_p) begin
            if (state_q == IDLE) begin
                state_d = RUN;
                presc_d = '0;
            end else if (state_q == RUN) begin
                state_d = PAUSE;
            end else begin
                // Resume from PAUSE keeps the held prescaler phase
                state_d = RUN;
            end
        end else if (lap_p && (state_q != IDLE)) begin
            lap_valid_d = 1'b1;
            lap_hh_d    = hh;
            lap_mm_d    = mm;
            lap_ss_d    = ss;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            start_q     <= 1'b0;
            clear_q     <= 1'b0;
            running_q   <= 1'b0;
            lap_valid_q <= 1'b0;
            lap_hh_q    <= '0;
            lap_mm_q    <= '0;
            lap_ss_q    <= '0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            start_q     <= start_d;
            // Decoded from the next state so the flags line up with state_q
            clear_q     <= (state_d == CLEAR);
            running_q   <= (state_d == RUN);
            lap_valid_q <= lap_valid_d;
            lap_hh_q    <= lap_hh_d;
            lap_mm_q    <= lap_mm_d;
            lap_ss_q    <= lap_ss_d;
        end
    end

    assign start_r   = start_q;
    assign clear     = clear_q;
    assign running   = running_q;
    assign lap_valid = lap_valid_q;
    assign lap_hh    = lap_hh_q;
    assign lap_mm    = lap_mm_q;
    assign lap_ss    = lap_ss_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
//==============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Self-checking bench for stopwatch_ctrl with directed scenarios
//               and a randomized run against a behavioural model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_stopwatch_ctrl;

    localparam int TICK_DIV   = 4;
    localparam int DEB_CYCLES = 3;
    localparam int CNT_W      = 3;
    localparam int DEB_W      = 2;

    logic       ap_clk   = 1'b0;
    logic       ap_rst_n = 1'b1;
    logic       btn_run  = 1'b0;
    logic       btn_clr  = 1'b0;
    logic       btn_lap  = 1'b0;
    logic [7:0] hh = 8'h00;
    logic [7:0] mm = 8'h00;
    logic [7:0] ss = 8'h00;
    logic       start_r;
    logic       clear;
    logic [7:0] lap_hh;
    logic [7:0] lap_mm;
    logic [7:0] lap_ss;
    logic       lap_valid;
    logic       running;

    int total = 0;
    int bad   = 0;

    stopwatch_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W),
        .DEB_W      (DEB_W)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .btn_run   (btn_run),
        .btn_clr   (btn_clr),
        .btn_lap   (btn_lap),
        .hh        (hh),
        .mm        (mm),
        .ss        (ss),
        .start_r   (start_r),
        .clear     (clear),
        .lap_hh    (lap_hh),
        .lap_mm    (lap_mm),
        .lap_ss    (lap_ss),
        .lap_valid (lap_valid),
        .running   (running)
    );

    always #5 ap_clk = ~ap_clk;

    // ------------------------------------------------------------------
    // Behavioural model. Buttons: a level flips once the last DEB_CYCLES
    // values seen two edges late all disagree with it. Mode: 0 idle,
    // 1 run, 2 pause, 3 clear. Ticks come from the number of RUN cycles.
    // ------------------------------------------------------------------
    int                    m_mode;
    int                    m_run_cnt;
    bit                    m_prs [3];
    bit                    m_lvl [3];
    logic [DEB_CYCLES+1:0] m_rh  [3];
    bit                    m_start;
    bit                    m_lap_valid;
    logic [7:0]            m_lhh, m_lmm, m_lss;

    function automatic void model_reset();
        m_mode = 0; m_run_cnt = 0; m_start = 0; m_lap_valid = 0;
        m_lhh = 0; m_lmm = 0; m_lss = 0;
        for (int b = 0; b < 3; b++) begin
            m_prs[b] = 0; m_lvl[b] = 0; m_rh[b] = '0;
        end
    endfunction

    function automatic void model_edge();
        bit                  raw  [3];
        bit                  nprs [3];
        logic [DEB_CYCLES-1:0] win;
        raw[0] = btn_run; raw[1] = btn_clr; raw[2] = btn_lap;
        m_start = 0;
        if (m_mode == 3) begin
            m_mode = 0;
        end else begin
            if (m_mode == 1) begin
                m_run_cnt++;
                m_start = ((m_run_cnt % TICK_DIV) == 0);
            end
            if (m_prs[1]) begin
                m_mode = 3; m_start = 0;
                m_lap_valid = 0; m_lhh = 0; m_lmm = 0; m_lss = 0;
            end else if (m_prs[0]) begin
                if (m_mode == 0) begin
                    m_mode = 1; m_run_cnt = 0;
                end else begin
                    m_mode = (m_mode == 1) ? 2 : 1;
                end
            end else if (m_prs[2] && m_mode != 0) begin
                m_lap_valid = 1; m_lhh = hh; m_lmm = mm; m_lss = ss;
            end
        end
        for (int b = 0; b < 3; b++) begin
            m_rh[b] = {m_rh[b][DEB_CYCLES:0], raw[b]};
            win     = m_rh[b][DEB_CYCLES+1:2];
            nprs[b] = 0;
            if (m_lvl[b] ? (win == '0) : (&win)) begin
                m_lvl[b] = ~m_lvl[b];
                nprs[b]  = m_lvl[b];
            end
        end
        for (int b = 0; b < 3; b++) m_prs[b] = nprs[b];
    endfunction

    // One clock: advance the model on the edge, return 1 time unit later
    task automatic step();
        @(posedge ap_clk);
        model_edge();
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        #2 ap_rst_n = 1'b0;
        #1;
        total++;
        if ({start_r, clear, lap_valid, running, lap_hh, lap_mm, lap_ss} !== 28'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {start_r, clear, lap_valid, running, lap_hh, lap_mm, lap_ss});
        end
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        model_reset();
        step();
        total++;
        if (running !== 1'b0 || clear !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: running=%b clear=%b expected 0 0", running, clear);
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 8; i++) begin
            btn_run = (i % 2 == 0);
            step();
            total++;
            if (running !== 1'b0) begin
                bad++;
                $display("FAIL bounce_toggle: running=%b expected 0", running);
            end
        end
        btn_run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (running !== 1'b0) begin
                bad++;
                $display("FAIL bounce_hold: running=%b expected 0", running);
            end
        end
    endtask

    task automatic test_run();
        int rise_t;
        bit exp_s;
        rise_t  = 0;
        btn_run = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            step();
            if (t == 10) btn_run = 1'b0;
            if (running === 1'b1 && rise_t == 0) rise_t = t;
            exp_s = (t == 10 || t == 14 || t == 18);
            total++;
            if (start_r !== exp_s) begin
                bad++;
                $display("FAIL run_start_r t=%0d: got %b expected %b", t, start_r, exp_s);
            end
            total++;
            if (clear !== 1'b0) begin
                bad++;
                $display("FAIL run_clear t=%0d: got %b expected 0", t, clear);
            end
        end
        total++;
        if (rise_t != 6) begin
            bad++;
            $display("FAIL run_latency: running rose at %0d expected 6", rise_t);
        end
    endtask

    task automatic test_pause_resume();
        int rise_t;
        int tick_t;
        // Align so the pause edge leaves the prescaler at 2
        for (int g = 0; g < 8 && (m_run_cnt % TICK_DIV) != 0; g++) step();
        btn_run = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            step();
            if (t == 4) btn_run = 1'b0;
            if (t == 5 || t == 6) begin
                total++;
                if (running !== (t == 5)) begin
                    bad++;
                    $display("FAIL pause_edge t=%0d: running=%b expected %b", t, running, (t == 5));
                end
            end
        end
        for (int t = 0; t < 20; t++) begin
            step();
            total++;
            if (start_r !== 1'b0 || running !== 1'b0) begin
                bad++;
                $display("FAIL paused: start_r=%b running=%b expected 0 0", start_r, running);
            end
        end
        rise_t  = 0;
        tick_t  = 0;
        btn_run = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            step();
            if (t == 4) btn_run = 1'b0;
            if (running === 1'b1 && rise_t == 0) rise_t = t;
            if (start_r === 1'b1 && tick_t == 0) tick_t = t;
        end
        total++;
        if (rise_t == 0 || tick_t - rise_t != 2) begin
            bad++;
            $display("FAIL resume_phase: start_r %0d cycles after running expected 2", tick_t - rise_t);
        end
    endtask

    task automatic test_lap();
        int first_t;
        first_t = 0;
        hh = 8'h01; mm = 8'h02; ss = 8'h03;
        btn_lap = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            step();
            if (t == 4) btn_lap = 1'b0;
            if (lap_valid === 1'b1 && first_t == 0) first_t = t;
        end
        total++;
        if (first_t != 6) begin
            bad++;
            $display("FAIL lap_latency: lap_valid at %0d expected 6", first_t);
        end
        total++;
        if ({lap_hh, lap_mm, lap_ss} !== 24'h010203) begin
            bad++;
            $display("FAIL lap_value: got %h expected 010203", {lap_hh, lap_mm, lap_ss});
        end
        ss = 8'h04;
        btn_lap = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            step();
            if (t == 4) btn_lap = 1'b0;
        end
        total++;
        if ({lap_hh, lap_mm, lap_ss, lap_valid} !== {24'h010204, 1'b1}) begin
            bad++;
            $display("FAIL lap_overwrite: got %h/%b expected 010204/1",
                     {lap_hh, lap_mm, lap_ss}, lap_valid);
        end
    endtask

    task automatic test_clear_run();
        int n_clr;
        n_clr   = 0;
        btn_run = 1'b1;
        btn_clr = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            step();
            if (t == 4) begin btn_run = 1'b0; btn_clr = 1'b0; end
            if (clear === 1'b1) n_clr++;
            if (t == 6) begin
                total++;
                if (clear !== 1'b1 || lap_valid !== 1'b0 || running !== 1'b0) begin
                    bad++;
                    $display("FAIL clear_edge: clear=%b lap_valid=%b running=%b expected 1 0 0",
                             clear, lap_valid, running);
                end
            end
        end
        total++;
        if (n_clr != 1) begin
            bad++;
            $display("FAIL clear_count: got %0d expected 1", n_clr);
        end
        total++;
        if (running !== 1'b0 || {lap_hh, lap_mm, lap_ss} !== 24'h0) begin
            bad++;
            $display("FAIL clear_after: running=%b lap=%h expected 0 000000",
                     running, {lap_hh, lap_mm, lap_ss});
        end
        // IDLE ignores lap presses, PAUSE would not
        btn_lap = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            step();
            if (t == 4) btn_lap = 1'b0;
        end
        total++;
        if (lap_valid !== 1'b0) begin
            bad++;
            $display("FAIL clear_to_idle: lap_valid=%b expected 0", lap_valid);
        end
    endtask

    task automatic test_async_reset();
        btn_run = 1'b1;
        for (int t = 1; t <= 12; t++) begin step(); if (t == 4) btn_run = 1'b0; end
        btn_lap = 1'b1;
        for (int t = 1; t <= 12; t++) begin step(); if (t == 4) btn_lap = 1'b0; end
        total++;
        if (running !== 1'b1 || lap_valid !== 1'b1) begin
            bad++;
            $display("FAIL areset_pre: running=%b lap_valid=%b expected 1 1", running, lap_valid);
        end
        #2 ap_rst_n = 1'b0;
        #1;
        total++;
        if ({start_r, clear, lap_valid, running, lap_hh, lap_mm, lap_ss} !== 28'h0) begin
            bad++;
            $display("FAIL areset_immediate: got %h expected 0",
                     {start_r, clear, lap_valid, running, lap_hh, lap_mm, lap_ss});
        end
        #1 ap_rst_n = 1'b1;
        model_reset();
        for (int t = 0; t < 16; t++) begin
            step();
            total++;
            if (running !== 1'b0 || start_r !== 1'b0 || lap_valid !== 1'b0) begin
                bad++;
                $display("FAIL areset_idle: running=%b start_r=%b lap_valid=%b expected 0 0 0",
                         running, start_r, lap_valid);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) btn_run = ~btn_run;
            if ($urandom_range(0, 24) == 0) btn_clr = ~btn_clr;
            if ($urandom_range(0, 9) == 0) btn_lap = ~btn_lap;
            hh = 8'($urandom); mm = 8'($urandom); ss = 8'($urandom);
            step();
            total++;
            if (running !== (m_mode == 1) || clear !== (m_mode == 3) || start_r !== m_start) begin
                bad++;
                $display("FAIL rand_ctrl i=%0d: run/clr/start=%b%b%b expected %b%b%b", i,
                         running, clear, start_r, (m_mode == 1), (m_mode == 3), m_start);
            end
            total++;
            if ({lap_valid, lap_hh, lap_mm, lap_ss} !== {m_lap_valid, m_lhh, m_lmm, m_lss}) begin
                bad++;
                $display("FAIL rand_lap i=%0d: got %h expected %h", i,
                         {lap_valid, lap_hh, lap_mm, lap_ss}, {m_lap_valid, m_lhh, m_lmm, m_lss});
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bounce();
        test_run();
        test_pause_resume();
        test_lap();
        test_clear_run();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
